clk_period_monitor: RTL and testbench

Measures the period and high time of a slow clock-like signal (typically the `buff_clk` output of the buffer clock stage) in units of `master_clk` cycles. Sits directly downstream of the buffer clock stage and replaces bench-side `$time` arithmetic with a synthesizable, self-checking measurement. Compares the measured period against an expected value with tolerance and flags pass, fail or timeout.

---
 rtl/clk_mon_pkg.sv | 24 ++
 rtl/sync_edge_det.sv | 42 ++++
 rtl/clk_period_monitor.sv | 159 +++++++++++++++
 tb/tb_clk_period_monitor.sv | 252 +++++++++++++++++++++++++
 4 files changed

// File: rtl/clk_mon_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : clk_mon_pkg
//  Description : Shared types and defaults for the clock period monitor and
//                its synchronizer / edge-detector sub-block.
//  Revision    : 1.0 - initial release
// ============================================================================
package clk_mon_pkg;

    // Default width of the period, high-time, expected and tolerance fields
    localparam int DEFAULT_CNT_W       = 16;
    // Default synchronizer depth on the monitored signal
    localparam int DEFAULT_SYNC_STAGES = 2;

    // Measurement controller states
    typedef enum logic [1:0] {
        IDLE      = 2'd0,
        WAIT_RISE = 2'd1,
        MEASURE   = 2'd2,
        DONE      = 2'd3
    } state_t;

endpackage : clk_mon_pkg
`default_nettype wire

// File: rtl/sync_edge_det.sv
`default_nettype none
// ============================================================================
//  Module      : sync_edge_det
//  Description : Multi-flop synchronizer for an asynchronous input followed
//                by a one-flop delay, producing single-cycle rise and fall
//                strobes in the local clock domain.
//  Revision    : 1.0 - initial release
// ============================================================================
module sync_edge_det
    import clk_mon_pkg::*;
#(
    parameter int SYNC_STAGES = DEFAULT_SYNC_STAGES
) (
    input  logic clk,
    input  logic rst,
    input  logic i_sig,
    output logic o_rise,
    output logic o_fall
);

    logic [SYNC_STAGES-1:0] r_sync;
    logic                   r_dly;
    logic                   w_synced;

    assign w_synced = r_sync[SYNC_STAGES-1];

    // Shift the raw input through the synchronizer, then keep one delayed copy
    always_ff @(posedge clk) begin
        if (rst) begin
            r_sync <= '0;
            r_dly  <= 1'b0;
        end else begin
            r_sync <= {r_sync[SYNC_STAGES-2:0], i_sig};
            r_dly  <= w_synced;
        end
    end

    assign o_rise = w_synced & ~r_dly;
    assign o_fall = ~w_synced & r_dly;

endmodule : sync_edge_det
`default_nettype wire

// File: rtl/clk_period_monitor.sv
`default_nettype none
// ============================================================================
//  Module      : clk_period_monitor
//  Description : Measures period and high time of a slow clock-like signal in
//                master_clk cycles, compares the period against an expected
//                value with tolerance and reports pass / fail / timeout.
//  Revision    : 1.0 - initial release
// ============================================================================
module clk_period_monitor
    import clk_mon_pkg::*;
#(
    parameter int          CNT_W       = DEFAULT_CNT_W,
    parameter int          SYNC_STAGES = DEFAULT_SYNC_STAGES,
    parameter int unsigned TIMEOUT     = (1 << CNT_W) - 1
) (
    input  logic             master_clk,
    input  logic             rst,
    input  logic             sig_in,
    input  logic             start,
    input  logic [CNT_W-1:0] expected_period,
    input  logic [CNT_W-1:0] tolerance,
    output logic             busy,
    output logic             done,
    output logic [CNT_W-1:0] period,
    output logic [CNT_W-1:0] high_time,
    output logic             pass,
    output logic             timeout
);

    localparam logic [CNT_W-1:0] c_timeout = TIMEOUT[CNT_W-1:0];
    localparam logic [CNT_W-1:0] c_one     = {{(CNT_W-1){1'b0}}, 1'b1};

    state_t           r_state;
    logic [CNT_W-1:0] r_cnt;
    logic [CNT_W-1:0] r_exp;
    logic [CNT_W-1:0] r_tol;
    logic             r_busy;
    logic             r_done;
    logic [CNT_W-1:0] r_period;
    logic [CNT_W-1:0] r_high;
    logic             r_pass;
    logic             r_timeout;

    logic             w_rise;
    logic             w_fall;
    logic [CNT_W:0]   w_diff;
    logic             w_in_tol;
    logic             w_cnt_max;

    sync_edge_det #(
        .SYNC_STAGES (SYNC_STAGES)
    ) u_sync (
        .clk    (master_clk),
        .rst    (rst),
        .i_sig  (sig_in),
        .o_rise (w_rise),
        .o_fall (w_fall)
    );

    // Absolute difference of the running count against the expected period,
    // one bit wider than the operands so the subtraction never wraps
    always_comb begin
        w_diff = '0;
        if (r_cnt >= r_exp) begin
            w_diff = {1'b0, r_cnt} - {1'b0, r_exp};
        end else begin
            w_diff = {1'b0, r_exp} - {1'b0, r_cnt};
        end
        w_in_tol  = (w_diff <= {1'b0, r_tol});
        w_cnt_max = (r_cnt == c_timeout);
    end

    // Measurement controller: counter, capture registers and result flags
    always_ff @(posedge master_clk) begin
        if (rst) begin
            r_state   <= IDLE;
            r_cnt     <= '0;
            r_exp     <= '0;
            r_tol     <= '0;
            r_busy    <= 1'b0;
            r_done    <= 1'b0;
            r_period  <= '0;
            r_high    <= '0;
            r_pass    <= 1'b0;
            r_timeout <= 1'b0;
        end else begin
            case (r_state)
                IDLE: begin
                    // A rise in this cycle is deliberately not used; the
                    // first counted rise is found in WAIT_RISE.
                    if (start) begin
                        r_state   <= WAIT_RISE;
                        r_exp     <= expected_period;
                        r_tol     <= tolerance;
                        r_period  <= '0;
                        r_high    <= '0;
                        r_pass    <= 1'b0;
                        r_timeout <= 1'b0;
                        r_cnt     <= '0;
                        r_busy    <= 1'b1;
                    end
                end
                WAIT_RISE: begin
                    if (w_cnt_max) begin
                        r_state   <= DONE;
                        r_timeout <= 1'b1;
                        r_done    <= 1'b1;
                        r_busy    <= 1'b0;
                    end else if (w_rise) begin
                        r_state <= MEASURE;
                        r_cnt   <= c_one;
                    end else begin
                        r_cnt <= r_cnt + c_one;
                    end
                end
                MEASURE: begin
                    if (w_cnt_max) begin
                        // Aborted: partial captures are discarded
                        r_state   <= DONE;
                        r_timeout <= 1'b1;
                        r_period  <= '0;
                        r_high    <= '0;
                        r_pass    <= 1'b0;
                        r_done    <= 1'b1;
                        r_busy    <= 1'b0;
                    end else if (w_rise) begin
                        r_state  <= DONE;
                        r_period <= r_cnt;
                        r_pass   <= w_in_tol;
                        r_done   <= 1'b1;
                        r_busy   <= 1'b0;
                    end else begin
                        if (w_fall) begin
                            r_high <= r_cnt;
                        end
                        r_cnt <= r_cnt + c_one;
                    end
                end
                DONE: begin
                    // Results are already registered; close the done pulse
                    r_state <= IDLE;
                    r_done  <= 1'b0;
                end
                default: begin
                    r_state <= IDLE;
                end
            endcase
        end
    end

    assign busy      = r_busy;
    assign done      = r_done;
    assign period    = r_period;
    assign high_time = r_high;
    assign pass      = r_pass;
    assign timeout   = r_timeout;

endmodule : clk_period_monitor
`default_nettype wire

// File: tb/tb_clk_period_monitor.sv
`default_nettype none
// ============================================================================
//  Module      : tb_clk_period_monitor
//  Description : Directed self-checking bench for clk_period_monitor with a
//                scoreboard of expected measurement results.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_clk_period_monitor;
    import clk_mon_pkg::*;

    logic        master_clk = 1'b0;
    logic        rst        = 1'b1;
    logic        sig_in     = 1'b0;
    logic        start      = 1'b0;
    logic [15:0] expected_period = '0;
    logic [15:0] tolerance       = '0;
    logic        busy;
    logic        done;
    logic [15:0] period;
    logic [15:0] high_time;
    logic        pass;
    logic        timeout;

    typedef struct {
        logic [15:0] per;
        logic [15:0] hi;
        logic        ok;
        logic        to;
    } exp_t;

    exp_t sb_q[$];

    int vectors    = 0;
    int miscompares = 0;
    int done_cnt   = 0;

    bit gen_en = 1'b0;
    int hi_cyc = 4;
    int lo_cyc = 4;

    clk_period_monitor #(
        .CNT_W       (16),
        .SYNC_STAGES (2),
        .TIMEOUT     (50)
    ) u_dut (
        .master_clk      (master_clk),
        .rst             (rst),
        .sig_in          (sig_in),
        .start           (start),
        .expected_period (expected_period),
        .tolerance       (tolerance),
        .busy            (busy),
        .done            (done),
        .period          (period),
        .high_time       (high_time),
        .pass            (pass),
        .timeout         (timeout)
    );

    always #20 master_clk = ~master_clk;

    // Signal under test, phase-locked to the falling edge of master_clk
    initial begin
        forever begin
            if (!gen_en) begin
                @(negedge master_clk);
            end else begin
                sig_in = 1'b1;
                repeat (hi_cyc) @(negedge master_clk);
                sig_in = 1'b0;
                repeat (lo_cyc) @(negedge master_clk);
            end
        end
    end

    // Count done pulses
    always @(negedge master_clk) begin
        if (done) done_cnt <= done_cnt + 1;
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, "_busy"},    busy,      0);
        check({tag, "_done"},    done,      0);
        check({tag, "_period"},  period,    0);
        check({tag, "_high"},    high_time, 0);
        check({tag, "_pass"},    pass,      0);
        check({tag, "_timeout"}, timeout,   0);
    endtask

    // Launch one measurement, wait for done, score it against the queue head
    task automatic run_meas(input string tag, input logic [15:0] e, input logic [15:0] t,
                            input exp_t x, input bit align, input bit dup,
                            output int busy_cycles);
        int   guard;
        bit   got;
        exp_t h;
        sb_q.push_back(x);
        if (align) begin
            guard = 0;
            while (!u_dut.w_rise && guard < 100) begin
                @(negedge master_clk);
                guard++;
            end
            check({tag, "_align_found"}, u_dut.w_rise, 1);
        end
        expected_period = e;
        tolerance       = t;
        start           = 1'b1;
        @(negedge master_clk);
        start       = 1'b0;
        busy_cycles = busy ? 1 : 0;
        check({tag, "_busy"}, busy, 1);
        if (dup) begin
            @(negedge master_clk);
            busy_cycles++;
            start = 1'b1;
            @(negedge master_clk);
            busy_cycles++;
            start = 1'b0;
        end
        got   = 1'b0;
        guard = 0;
        while (!got && guard < 300) begin
            @(negedge master_clk);
            guard++;
            if (done) got = 1'b1;
            else if (busy) busy_cycles++;
        end
        if (!got) begin
            check({tag, "_done_seen"}, 0, 1);
            void'(sb_q.pop_front());
        end else begin
            h = sb_q.pop_front();
            check({tag, "_period"},  period,    h.per);
            check({tag, "_high"},    high_time, h.hi);
            check({tag, "_pass"},    pass,      h.ok);
            check({tag, "_timeout"}, timeout,   h.to);
            check({tag, "_busy_low"}, busy,     0);
        end
    endtask

    initial begin
        int   bc;
        int   dc0;
        int   guard;
        exp_t x;

        // Reset state
        repeat (3) @(negedge master_clk);
        check_all_zero("reset");
        rst = 1'b0;

        // Nominal 8-cycle period, 50% duty
        hi_cyc = 4; lo_cyc = 4; gen_en = 1'b1;
        repeat (12) @(negedge master_clk);
        dc0 = done_cnt;
        x = '{per: 16'd8, hi: 16'd4, ok: 1'b1, to: 1'b0};
        run_meas("nominal", 16'd8, 16'd0, x, 1'b0, 1'b0, bc);
        repeat (5) @(negedge master_clk);
        #1;
        check("nominal_done_pulses", done_cnt - dc0, 1);
        check("nominal_hold_period", period, 8);
        check("nominal_hold_done", done, 0);

        // Duty cycle 3 high / 7 low
        hi_cyc = 3; lo_cyc = 7;
        repeat (25) @(negedge master_clk);
        x = '{per: 16'd10, hi: 16'd3, ok: 1'b1, to: 1'b0};
        run_meas("duty", 16'd10, 16'd1, x, 1'b0, 1'b0, bc);

        // Period 12 against expected 8 +/- 2: out of tolerance
        hi_cyc = 6; lo_cyc = 6;
        repeat (25) @(negedge master_clk);
        x = '{per: 16'd12, hi: 16'd6, ok: 1'b0, to: 1'b0};
        run_meas("out_tol", 16'd8, 16'd2, x, 1'b0, 1'b0, bc);
        repeat (3) @(negedge master_clk);

        // Deviation exactly equal to tolerance passes
        x = '{per: 16'd12, hi: 16'd6, ok: 1'b1, to: 1'b0};
        run_meas("tol_edge", 16'd10, 16'd2, x, 1'b0, 1'b0, bc);
        repeat (3) @(negedge master_clk);

        // Expected above measured, one beyond tolerance
        x = '{per: 16'd12, hi: 16'd6, ok: 1'b0, to: 1'b0};
        run_meas("exp_above", 16'd14, 16'd1, x, 1'b0, 1'b0, bc);

        // Stuck-low input: timeout after 51 busy cycles
        gen_en = 1'b0;
        repeat (30) @(negedge master_clk);
        x = '{per: 16'd0, hi: 16'd0, ok: 1'b0, to: 1'b1};
        run_meas("stuck", 16'd8, 16'd0, x, 1'b0, 1'b0, bc);
        check("stuck_busy_cycles", bc, 51);

        // Start pulsed again while busy: exactly one done
        hi_cyc = 4; lo_cyc = 4; gen_en = 1'b1;
        repeat (12) @(negedge master_clk);
        dc0 = done_cnt;
        x = '{per: 16'd8, hi: 16'd4, ok: 1'b1, to: 1'b0};
        run_meas("dup_start", 16'd8, 16'd0, x, 1'b0, 1'b1, bc);
        repeat (30) @(negedge master_clk);
        #1;
        check("dup_start_done_pulses", done_cnt - dc0, 1);

        // Start coincident with a rise detect in IDLE
        x = '{per: 16'd8, hi: 16'd4, ok: 1'b1, to: 1'b0};
        run_meas("start_on_rise", 16'd8, 16'd0, x, 1'b1, 1'b0, bc);
        repeat (3) @(negedge master_clk);

        // Reset in the middle of MEASURE, then a clean measurement
        expected_period = 16'd8;
        tolerance       = 16'd0;
        start = 1'b1;
        @(negedge master_clk);
        start = 1'b0;
        guard = 0;
        while (u_dut.r_state != MEASURE && guard < 100) begin
            @(negedge master_clk);
            guard++;
        end
        check("rst_reached_measure", (u_dut.r_state == MEASURE) ? 1 : 0, 1);
        repeat (2) @(negedge master_clk);
        rst = 1'b1;
        @(negedge master_clk);
        check_all_zero("mid_rst");
        rst = 1'b0;
        repeat (12) @(negedge master_clk);
        x = '{per: 16'd8, hi: 16'd4, ok: 1'b1, to: 1'b0};
        run_meas("after_rst", 16'd8, 16'd0, x, 1'b0, 1'b0, bc);

        check("scoreboard_empty", sb_q.size(), 0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

    // Global time bound so the bench always terminates
    initial begin
        #2000000;
        $display("FAIL global_timeout: observed running expected finished");
        $fatal(1, "simulation time limit reached");
    end

endmodule : tb_clk_period_monitor
`default_nettype wire
